// File: rtl/nibble_serializer.sv
// rtl/nibble_serializer.sv - nibble FIFO feeding a gapless one-bit-per-clock serializer with frame strobe
module nibble_serializer #(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       r,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       D,
  output logic       frame,
  output logic       busy,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    sr;
  logic [3:0]    sr_shift;
  logic [3:0]    head;
  logic [1:0]    bit_cnt;
  logic          push;
  logic          pop;

  assign empty     = (count == '0);
  assign din_ready = (count != FULL_COUNT);
  assign push      = din_valid && din_ready;
  // The last bit of a nibble pops the next one so back-to-back nibbles have no gap.
  assign pop       = !empty && ((state == IDLE) || (bit_cnt == 2'd3));
  assign head      = mem[rd_ptr];
  assign sr_shift  = MSB_FIRST ? {sr[2:0], 1'b0} : {1'b0, sr[3:1]};

  function automatic logic lead_bit(input logic [3:0] n);
    return MSB_FIRST ? n[3] : n[0];
  endfunction

  always_ff @(posedge clk) begin
    if (push && !r) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (r) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      D       <= 1'b0;
      frame   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= SHIFT;
            sr      <= head;
            bit_cnt <= '0;
            D       <= lead_bit(head);
            frame   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          if (bit_cnt != 2'd3) begin
            sr      <= sr_shift;
            bit_cnt <= bit_cnt + 2'd1;
            D       <= lead_bit(sr_shift);
            frame   <= 1'b0;
          end else if (pop) begin
            sr      <= head;
            bit_cnt <= '0;
            D       <= lead_bit(head);
            frame   <= 1'b1;
          end else begin
            state   <= IDLE;
            sr      <= '0;
            bit_cnt <= '0;
            D       <= 1'b0;
            frame   <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serializer.sv
// tb/tb_nibble_serializer.sv - table vectors, corner sequences and random traffic against a queue model
module tb_nibble_serializer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r;
  logic       din_valid;
  logic [3:0] din;
  logic       rdy_m, d_m, fr_m, bs_m, emp_m;
  logic       rdy_l, d_l, fr_l, bs_l, emp_l;

  nibble_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .r(r), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
    .D(d_m), .frame(fr_m), .busy(bs_m), .empty(emp_m)
  );

  nibble_serializer #(.DEPTH(DEPTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .r(r), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
    .D(d_l), .frame(fr_l), .busy(bs_l), .empty(emp_l)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a nibble queue plus "bits left in the current nibble".
  logic [3:0] mq[$];
  int         m_left = 0;
  int         m_pos  = 0;
  logic [3:0] m_cur  = 4'h0;

  function automatic void model_edge(input logic ri, input logic vi, input logic [3:0] di);
    bit rdy_pre;
    if (ri) begin
      mq.delete();
      m_left = 0;
      m_pos  = 0;
      m_cur  = 4'h0;
      return;
    end
    rdy_pre = (mq.size() < DEPTH);
    if (m_left > 1) begin
      m_left--;
      m_pos++;
    end else if (mq.size() > 0) begin
      m_cur  = mq.pop_front();
      m_left = 4;
      m_pos  = 0;
    end else begin
      m_left = 0;
    end
    if (vi && rdy_pre) mq.push_back(di);
  endfunction

  task automatic check_model();
    logic em, el;
    em = (m_left > 0) ? m_cur[3 - m_pos] : 1'b0;
    el = (m_left > 0) ? m_cur[m_pos]     : 1'b0;
    chk("model msb D",     d_m,   em);
    chk("model msb frame", fr_m,  m_left == 4);
    chk("model msb busy",  bs_m,  m_left > 0);
    chk("model msb ready", rdy_m, mq.size() < DEPTH);
    chk("model msb empty", emp_m, mq.size() == 0);
    chk("model lsb D",     d_l,   el);
    chk("model lsb frame", fr_l,  m_left == 4);
    chk("model lsb busy",  bs_l,  m_left > 0);
    chk("model lsb ready", rdy_l, mq.size() < DEPTH);
    chk("model lsb empty", emp_l, mq.size() == 0);
  endtask

  // Rebuild nibbles seen on the MSB-first instance's serial output.
  logic [3:0] got[$];
  logic [3:0] col_val = 4'h0;
  int         col_bits = 0;

  task automatic collect();
    if (bs_m) begin
      if (fr_m) begin
        col_val  = {3'b000, d_m};
        col_bits = 1;
      end else begin
        col_val  = {col_val[2:0], d_m};
        col_bits++;
      end
      if (col_bits == 4) got.push_back(col_val);
    end
  endtask

  task automatic step(input logic ri, input logic vi, input logic [3:0] di);
    r = ri;
    din_valid = vi;
    din = di;
    @(posedge clk);
    model_edge(ri, vi, di);
    #1;
    check_model();
    collect();
  endtask

  typedef struct {
    logic       r;
    logic       v;
    logic [3:0] din;
    logic       d;
    logic       fr;
    logic       bs;
    logic       rdy;
    logic       emp;
  } vec_t;

  function automatic vec_t mk(input logic ri, vi, input logic [3:0] di,
                              input logic d, fr, bs, rdy, emp);
    vec_t v;
    v.r = ri; v.v = vi; v.din = di;
    v.d = d; v.fr = fr; v.bs = bs; v.rdy = rdy; v.emp = emp;
    return v;
  endfunction

  vec_t       vt[$];
  logic [15:0] b2b_bits = 16'b1010_0101_1100_0011;
  logic [3:0]  b2b_nibs[4] = '{4'hA, 4'h5, 4'hC, 4'h3};
  logic [3:0]  bp_nibs[6]  = '{4'h9, 4'h6, 4'hE, 4'h1, 4'h7, 4'hC};
  logic [3:0]  sp_nibs[4]  = '{4'h2, 4'hD, 4'h4, 4'hB};
  logic [7:0]  lsb_bits    = 8'b1000_0001;
  logic        rdy_hist[64];

  initial begin
    r = 1'b1;
    din_valid = 1'b0;
    din = 4'h0;

    // Single nibble 1011, then back-to-back A,5,C,3.
    vt.push_back(mk(1, 0, 4'h0,    0, 0, 0, 1, 1));
    vt.push_back(mk(0, 1, 4'b1011, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 0, 4'h0,    1, 1, 1, 1, 1));
    vt.push_back(mk(0, 0, 4'h0,    0, 0, 1, 1, 1));
    vt.push_back(mk(0, 0, 4'h0,    1, 0, 1, 1, 1));
    vt.push_back(mk(0, 0, 4'h0,    1, 0, 1, 1, 1));
    vt.push_back(mk(0, 0, 4'h0,    0, 0, 0, 1, 1));
    vt.push_back(mk(0, 0, 4'h0,    0, 0, 0, 1, 1));
    vt.push_back(mk(1, 0, 4'h0,    0, 0, 0, 1, 1));
    for (int i = 0; i < 18; i++) begin
      logic on;
      on = (i >= 1) && (i <= 16);
      vt.push_back(mk(0, i < 4, (i < 4) ? b2b_nibs[i] : 4'h0,
                      on ? b2b_bits[16 - i] : 1'b0,
                      on && ((i - 1) % 4 == 0),
                      on, 1'b1, i >= 13));
    end

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].v, vt[i].din);
      chk($sformatf("tbl%0d D", i),     d_m,   vt[i].d);
      chk($sformatf("tbl%0d frame", i), fr_m,  vt[i].fr);
      chk($sformatf("tbl%0d busy", i),  bs_m,  vt[i].bs);
      chk($sformatf("tbl%0d ready", i), rdy_m, vt[i].rdy);
      chk($sformatf("tbl%0d empty", i), emp_m, vt[i].emp);
    end

    // Backpressure: din_valid held high over six nibbles.
    step(1, 0, 4'h0);
    got.delete();
    begin
      int idx = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        logic acc;
        acc = (idx < 6) && rdy_m;
        step(0, idx < 6, (idx < 6) ? bp_nibs[idx] : 4'h0);
        rdy_hist[cyc] = rdy_m;
        if (acc) idx++;
      end
      chk("bp all accepted", idx, 6);
    end
    chk("bp ready low at count 4", rdy_hist[4], 1'b0);
    chk("bp ready back after pop", rdy_hist[5], 1'b1);
    chk("bp ready low again",      rdy_hist[6], 1'b0);
    chk("bp nibble count", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      chk($sformatf("bp nibble %0d", i), got[i], bp_nibs[i]);

    // Push on the same edge as the counter=3 pop, with two nibbles queued.
    step(1, 0, 4'h0);
    got.delete();
    step(0, 1, sp_nibs[0]);
    step(0, 1, sp_nibs[1]);
    step(0, 1, sp_nibs[2]);
    step(0, 0, 4'h0);
    step(0, 0, 4'h0);
    step(0, 1, sp_nibs[3]);
    chk("sp frame on pop edge", fr_m, 1'b1);
    chk("sp not empty", emp_m, 1'b0);
    for (int i = 0; i < 16; i++) step(0, 0, 4'h0);
    chk("sp nibble count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("sp nibble %0d", i), got[i], sp_nibs[i]);

    // Reset during bit 2 with three nibbles queued.
    step(1, 0, 4'h0);
    for (int i = 0; i < 4; i++) step(0, 1, bp_nibs[i]);
    step(1, 0, 4'h0);
    chk("rst D",     d_m,   1'b0);
    chk("rst busy",  bs_m,  1'b0);
    chk("rst frame", fr_m,  1'b0);
    chk("rst empty", emp_m, 1'b1);
    chk("rst ready", rdy_m, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 4'h0);
      chk("post-rst busy", bs_m, 1'b0);
    end

    // LSB-first: 0001 then 1000.
    step(1, 0, 4'h0);
    step(0, 1, 4'b0001);
    for (int i = 1; i <= 8; i++) begin
      step(0, i == 1, (i == 1) ? 4'b1000 : 4'h0);
      chk($sformatf("lsb D bit %0d", i), d_l, lsb_bits[8 - i]);
      chk($sformatf("lsb frame %0d", i), fr_l, (i == 1) || (i == 5));
    end
    step(0, 0, 4'h0);
    chk("lsb idle busy", bs_l, 1'b0);

    // Random traffic with occasional resets.
    step(1, 0, 4'h0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
